pe_scatter: RTL and testbench
=============================

PE_SCATTER -- requirements
Module: pe_scatter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter NUM_OUT, default 33, meaning number of output channels.
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(NUM_OUT), meaning channel-select width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  meaning an input beat is offered.
REQ-007 SHALL have port in_ready  output  1  meaning the offered beat is accepted this cycle.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  meaning payload.
REQ-009 SHALL have port in_sel  input  SEL_WIDTH  meaning target channel in unicast mode.
REQ-010 SHALL have port in_mode  input  2  meaning 00 unicast, 01 broadcast, 10 sequential, 11 treated as unicast.
REQ-011 SHALL have port in_last  input  1  meaning last beat of a sequential burst.
REQ-012 SHALL have port out_valid  output  NUM_OUT  meaning per-channel data valid.
REQ-013 SHALL have port out_ready  input  NUM_OUT  meaning per-channel consumer ready.
REQ-014 SHALL have port out_data  output  unpacked array [NUM_OUT-1:0] of DATA_WIDTH  meaning per-channel payload.
REQ-015 SHALL have port seq_ptr  output  SEL_WIDTH  meaning next channel for sequential mode.
REQ-016 SHALL have port oob_err  output  1  meaning one-cycle pulse when a beat targets a channel >= NUM_OUT.
REQ-017 SHALL have port busy  output  1  meaning OR of out_valid.

Function
REQ-018 SHALL hold one output register slot (valid + data) per channel; slot empties when out_valid[i] && out_ready[i].
REQ-019 SHALL define target set: unicast -> {in_sel}; broadcast -> all NUM_OUT channels; sequential -> {seq_ptr}.
REQ-020 SHALL drive in_ready = 1 iff every in-range target slot is empty or draining this cycle (combinational on out_valid/out_ready; no dependency on in_valid).
REQ-021 SHALL accept a beat when in_valid && in_ready; data appears on out_data/out_valid of each target on the cycle after acceptance (latency 1).
REQ-022 SHALL sustain one beat per cycle per channel when consumers hold out_ready high.
REQ-023 SHALL keep out_data[i] stable while out_valid[i] && !out_ready[i].
REQ-024 SHALL, when a slot drains and is refilled in the same cycle, load the new data and keep out_valid[i] = 1.
REQ-025 SHALL drive out_data[i] = 0 whenever out_valid[i] = 0.
REQ-026 SHALL, in unicast with in_sel >= NUM_OUT, hold in_ready = 1, accept and discard the beat, and pulse oob_err for one cycle after acceptance.
REQ-027 SHALL increment seq_ptr on each accepted sequential beat, wrapping NUM_OUT-1 -> 0.
REQ-028 SHALL set seq_ptr to 0 after an accepted sequential beat with in_last = 1 (overrides increment).
REQ-029 SHALL leave seq_ptr unchanged by unicast/broadcast beats and by mode changes; in_last ignored outside sequential mode.
REQ-030 SHALL not write any non-target slot; broadcast writes all slots atomically in one cycle or none.

Reset
REQ-031 SHALL, while rst = 1, force all out_valid = 0, all out_data = 0, seq_ptr = 0, oob_err = 0, busy = 0, and accept no beat (in_ready = 0).
REQ-032 SHALL discard all buffered beats on reset mid-operation; first acceptance possible the cycle after rst deasserts.

Verification
REQ-033 Unicast: NUM_OUT=33, in_sel=5, in_data=0xA5, all out_ready=1 -> next cycle out_valid=1<<5, out_data[5]=0xA5, others 0.
REQ-034 Backpressure: out_ready[5]=0, two unicast beats 0x11, 0x22 to ch 5 -> 0x11 held, in_ready=0 on second; raise out_ready[5] -> 0x22 appears next cycle, no loss/duplication.
REQ-035 Broadcast: out_ready[7]=0 with ch 7 full, broadcast 0x3C -> in_ready=0, no slot written; release ch 7 -> all 33 channels show 0x3C.
REQ-036 Sequential: 35 beats 0..34, in_last on beat 34 -> ch0..32 get 0..32, ch0,1 then get 33,34, seq_ptr returns to 0.
REQ-037 OOB: in_sel=40, in_valid=1 -> accepted, no out_valid, oob_err high exactly one cycle.
REQ-038 Reset: rst pulsed with 10 slots full and seq_ptr=12 -> next cycle all out_valid=0, out_data=0, seq_ptr=0.

Source files
------------

// File: rtl/pe_scatter.sv
// One-in, many-out scatter stage: each beat is written into the single-entry output slot of its
// target channel(s) (unicast, broadcast or round-robin), with per-channel valid/ready draining.
module pe_scatter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OUT    = 33,
  parameter int SEL_WIDTH  = $clog2(NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic [1:0]            in_mode,
  input  logic                  in_last,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic [DATA_WIDTH-1:0] out_data [NUM_OUT-1:0],
  output logic [SEL_WIDTH-1:0]  seq_ptr,
  output logic                  oob_err,
  output logic                  busy
);

  localparam logic [1:0] MODE_BCAST = 2'b01;
  localparam logic [1:0] MODE_SEQ   = 2'b10;

  logic [NUM_OUT-1:0]    valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_OUT-1:0];
  logic [DATA_WIDTH-1:0] data_d [NUM_OUT-1:0];
  logic [SEL_WIDTH-1:0]  seq_ptr_q, seq_ptr_d;
  logic                  oob_q, oob_d;
  logic [NUM_OUT-1:0]    tgt;
  logic [NUM_OUT-1:0]    free;
  logic                  sel_hit;
  logic                  accept;

  assign free = ~valid_q | out_ready;

  always_comb begin
    tgt     = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (in_mode == MODE_BCAST) begin
        tgt[i] = 1'b1;
      end else if (in_mode == MODE_SEQ) begin
        tgt[i] = (seq_ptr_q == SEL_WIDTH'(i));
      end else begin
        tgt[i] = (in_sel == SEL_WIDTH'(i));
      end
      if (in_sel == SEL_WIDTH'(i)) begin
        sel_hit = 1'b1;
      end
    end
    // An out-of-range unicast has an empty target set, so it is always ready.
    in_ready = !rst && ((tgt & ~free) == '0);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    valid_d   = (valid_q & ~out_ready) | ({NUM_OUT{accept}} & tgt);
    seq_ptr_d = seq_ptr_q;
    oob_d     = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      data_d[i] = (accept && tgt[i]) ? in_data : data_q[i];
    end
    if (accept && in_mode == MODE_SEQ) begin
      if (in_last || seq_ptr_q == SEL_WIDTH'(NUM_OUT - 1)) begin
        seq_ptr_d = '0;
      end else begin
        seq_ptr_d = seq_ptr_q + SEL_WIDTH'(1);
      end
    end
    if (accept && in_mode != MODE_BCAST && in_mode != MODE_SEQ && !sel_hit) begin
      oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      seq_ptr_q <= '0;
      oob_q     <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      seq_ptr_q <= seq_ptr_d;
      oob_q     <= oob_d;
      for (int i = 0; i < NUM_OUT; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Outputs are masked by rst so the block looks idle for the whole reset window.
  always_comb begin
    out_valid = rst ? '0 : valid_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_data[i] = out_valid[i] ? data_q[i] : '0;
    end
  end

  assign seq_ptr = rst ? '0 : seq_ptr_q;
  assign oob_err = oob_q && !rst;
  assign busy    = |out_valid;

endmodule

// File: tb/tb_pe_scatter.sv
// Bench for pe_scatter: directed scenarios followed by random traffic, all checked every cycle
// against a slot-level behavioural model.
module tb_pe_scatter;
  localparam int DW = 8;
  localparam int N  = 33;
  localparam int SW = $clog2(N);
  localparam int CW = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic [1:0]    in_mode;
  logic          in_last;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data [N-1:0];
  logic [SW-1:0] seq_ptr;
  logic          oob_err;
  logic          busy;

  always #5 clk = ~clk;

  pe_scatter #(.DATA_WIDTH(DW), .NUM_OUT(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .seq_ptr(seq_ptr), .oob_err(oob_err), .busy(busy)
  );

  // Reference model: one optional buffered byte per channel, a round-robin index, an error flag.
  bit            m_full [N];
  logic [DW-1:0] m_val  [N];
  int            m_ptr;
  bit            m_oob;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_tgt(int ch);
    if (in_mode == 2'd1) return 1'b1;
    if (in_mode == 2'd2) return ch == m_ptr;
    return ch == int'(in_sel);
  endfunction

  function automatic bit exp_ready();
    if (rst) return 1'b0;
    for (int ch = 0; ch < N; ch++)
      if (is_tgt(ch) && m_full[ch] && !out_ready[ch]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [CW-1:0] flat_data();
    logic [CW-1:0] f = '0;
    for (int ch = 0; ch < N; ch++) f[ch*DW +: DW] = out_data[ch];
    return f;
  endfunction

  task automatic drive(input bit v, input int mode, input int sel, input int data, input bit last);
    in_valid = v;
    in_mode  = 2'(mode);
    in_sel   = SW'(sel);
    in_data  = DW'(data);
    in_last  = last;
  endtask

  // Checks all outputs against the model, advances the model, and returns just after the edge.
  task automatic step();
    logic [N-1:0]  ev;
    logic [CW-1:0] ed;
    bit            acc;
    bit            wr;
    #1;
    ev = '0;
    ed = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (!rst && m_full[ch]) begin
        ev[ch] = 1'b1;
        ed[ch*DW +: DW] = m_val[ch];
      end
    end
    chk("in_ready",  CW'(in_ready),  CW'(exp_ready()));
    chk("out_valid", CW'(out_valid), CW'(ev));
    chk("out_data",  flat_data(),    ed);
    chk("seq_ptr",   CW'(seq_ptr),   rst ? '0 : CW'(m_ptr));
    chk("oob_err",   CW'(oob_err),   CW'(!rst && m_oob));
    chk("busy",      CW'(busy),      CW'(|ev));
    acc = in_valid && exp_ready();
    for (int ch = 0; ch < N; ch++) begin
      wr = acc && is_tgt(ch);
      if (rst) begin
        m_full[ch] = 1'b0;
      end else begin
        m_full[ch] = wr || (m_full[ch] && !out_ready[ch]);
        if (wr) m_val[ch] = in_data;
      end
    end
    m_oob = !rst && acc && (in_mode == 2'd0 || in_mode == 2'd3) && int'(in_sel) >= N;
    if (rst) m_ptr = 0;
    else if (acc && in_mode == 2'd2) m_ptr = in_last ? 0 : (m_ptr + 1) % N;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CW-1:0] all3c;
    logic [63:0]   r;
    int            rmode;
    m_ptr = 0;
    m_oob = 1'b0;
    for (int ch = 0; ch < N; ch++) begin
      m_full[ch] = 1'b0;
      m_val[ch]  = '0;
    end

    rst = 1'b1;
    out_ready = '1;
    drive(1'b0, 0, 0, 0, 1'b0);
    step();
    step();
    chk("rst_in_ready", CW'(in_ready), '0);
    rst = 1'b0;

    // Unicast
    drive(1'b1, 0, 5, 8'hA5, 1'b0);
    step();
    in_valid = 1'b0;
    chk("uni_valid", CW'(out_valid), CW'(1) << 5);
    chk("uni_data5", CW'(out_data[5]), CW'(8'hA5));
    chk("uni_data4", CW'(out_data[4]), '0);
    step();

    // Backpressure and same-cycle drain/refill
    out_ready[5] = 1'b0;
    drive(1'b1, 0, 5, 8'h11, 1'b0);
    step();
    drive(1'b1, 0, 5, 8'h22, 1'b0);
    #1;
    chk("bp_ready_low", CW'(in_ready), '0);
    step();
    chk("bp_hold", CW'(out_data[5]), CW'(8'h11));
    out_ready[5] = 1'b1;
    step();
    chk("bp_refill_data", CW'(out_data[5]), CW'(8'h22));
    chk("bp_refill_valid", CW'(out_valid[5]), CW'(1'b1));
    in_valid = 1'b0;
    step();
    chk("bp_drained", CW'(out_valid), '0);

    // Broadcast blocked by one full channel, then released
    out_ready[7] = 1'b0;
    drive(1'b1, 0, 7, 8'h77, 1'b0);
    step();
    drive(1'b1, 1, 0, 8'h3C, 1'b0);
    #1;
    chk("bc_blocked", CW'(in_ready), '0);
    step();
    chk("bc_none_written", CW'(out_valid), CW'(1) << 7);
    chk("bc_ch7_kept", CW'(out_data[7]), CW'(8'h77));
    out_ready[7] = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = '0;
    for (int ch = 0; ch < N; ch++) all3c[ch*DW +: DW] = 8'h3C;
    chk("bc_all_valid", CW'(out_valid), CW'({N{1'b1}}));
    chk("bc_all_data", flat_data(), all3c);
    step();
    out_ready = '1;
    step();

    // Sequential burst wrapping past the last channel
    for (int b = 0; b < 35; b++) begin
      drive(1'b1, 2, 0, b, b == 34);
      step();
    end
    in_valid = 1'b0;
    chk("seq_ptr_back0", CW'(seq_ptr), '0);
    chk("seq_last_valid", CW'(out_valid), CW'(1) << 1);
    chk("seq_last_data", CW'(out_data[1]), CW'(8'd34));
    step();

    // Out-of-range unicast
    drive(1'b1, 0, 40, 8'h5A, 1'b0);
    #1;
    chk("oob_ready", CW'(in_ready), CW'(1'b1));
    step();
    in_valid = 1'b0;
    chk("oob_pulse", CW'(oob_err), CW'(1'b1));
    chk("oob_no_valid", CW'(out_valid), '0);
    step();
    chk("oob_one_cycle", CW'(oob_err), '0);

    // Reset mid-operation with full slots and a non-zero pointer
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 2, 0, 8'h80 + k, 1'b0);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = '0;
    for (int ch = 20; ch < 30; ch++) begin
      drive(1'b1, 0, ch, ch, 1'b0);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_ptr", CW'(seq_ptr), CW'(12));
    chk("pre_rst_fill", CW'($countones(out_valid)), CW'(10));
    rst = 1'b1;
    #1;
    chk("in_rst_valid", CW'(out_valid), '0);
    chk("in_rst_ready", CW'(in_ready), '0);
    step();
    rst = 1'b0;
    chk("post_rst_valid", CW'(out_valid), '0);
    chk("post_rst_data", flat_data(), '0);
    chk("post_rst_ptr", CW'(seq_ptr), '0);
    out_ready = '1;
    step();

    // Random traffic
    rmode = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0) rmode = int'($urandom_range(0, 2));
      r = {$urandom(), $urandom()};
      if (rmode == 0) out_ready = '1;
      else if (rmode == 1) out_ready = r[N-1:0];
      else out_ready = r[N-1:0] | N'({$urandom(), $urandom()}) | N'({$urandom(), $urandom()});
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
            int'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
